// File: rtl/mult_share_arbiter_pkg.sv
// Shared constants, response-entry type and round-robin helper for the
// four-port shared-multiplier arbiter.
package mult_arb_pkg;
    localparam int NREQ   = 4;
    localparam int ID_W   = 2;
    localparam int DATA_W = 8;
    localparam int PROD_W = 16;

    localparam int MUL_LAT_DEF    = 1;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TRUNC_BITS_DEF = 4;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [PROD_W-1:0] m;
        logic              sign;
    } rsp_entry_t;

    localparam int RSP_W = $bits(rsp_entry_t);

    // Returns {found, index} of the first set bit at or after ptr, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] vld,
                                              input logic [ID_W-1:0] ptr);
        logic [ID_W-1:0] idx;
        logic [ID_W:0]   res;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + ID_W'(k);
            if (vld[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction
endpackage

// File: rtl/mult_share_arbiter_if.sv
// Request, multiplier and response signals of mult_share_arbiter.
// slave = the arbiter, master = its environment (requesters, multiplier, sink).
interface mult_share_arbiter_if;
    import mult_arb_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DATA_W-1:0] req_a;
    logic [NREQ*DATA_W-1:0] req_b;
    logic [NREQ-1:0]        req_asign;
    logic [NREQ-1:0]        req_bsign;

    logic [DATA_W-1:0]      mul_a;
    logic [DATA_W-1:0]      mul_b;
    logic                   mul_asign;
    logic                   mul_bsign;
    logic [PROD_W-1:0]      mul_m;
    logic                   mul_sign;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [PROD_W-1:0]      rsp_m;
    logic                   rsp_sign;
    logic                   busy;

    modport slave (
        input  req_valid, req_a, req_b, req_asign, req_bsign,
        input  mul_m, mul_sign, rsp_ready,
        output req_ready, mul_a, mul_b, mul_asign, mul_bsign,
        output rsp_valid, rsp_id, rsp_m, rsp_sign, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_asign, req_bsign,
        output mul_m, mul_sign, rsp_ready,
        input  req_ready, mul_a, mul_b, mul_asign, mul_bsign,
        input  rsp_valid, rsp_id, rsp_m, rsp_sign, busy
    );
endinterface

// File: rtl/mult_share_arbiter_rsp_fifo.sv
// Synchronous response FIFO; power-of-two depth, simultaneous push/pop legal
// even when full.
module rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude multiplier among four ports,
// with credit-limited issue and an in-order response FIFO. Optional macro:
// APPROX_TRUNC_EN zeroes the TRUNC_BITS product LSBs on FIFO push.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int MUL_LAT    = MUL_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TRUNC_BITS = TRUNC_BITS_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    mult_share_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if (MUL_LAT < 1 || MUL_LAT > 4 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TRUNC_BITS < 0 || TRUNC_BITS > PROD_W)
    begin : g_bad_params
        $error("mult_share_arbiter: parameter out of range");
    end

    logic [ID_W-1:0]   r_rr_ptr;
    logic [DATA_W-1:0] r_mul_a;
    logic [DATA_W-1:0] r_mul_b;
    logic              r_mul_asign;
    logic              r_mul_bsign;
    logic [MUL_LAT-1:0] r_tag_vld;
    logic [ID_W-1:0]   r_tag_id [MUL_LAT];

    logic [ID_W:0]     w_pick;
    logic [ID_W-1:0]   w_gnt;
    logic              w_found;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [5:0]        w_outstanding;
    logic              w_credit;
    logic              w_xfer;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [PROD_W-1:0] w_push_m;
    rsp_entry_t        w_push_entry;
    rsp_entry_t        w_head;

    // Credit uses registered counts only, so a pop frees a slot one cycle later.
    always_comb begin
        w_outstanding = 6'(w_fifo_count);
        for (int i = 0; i < MUL_LAT; i++) begin
            w_outstanding = w_outstanding + 6'(r_tag_vld[i]);
        end
    end

    assign w_credit = (w_outstanding < 6'(FIFO_DEPTH));
    assign w_pick   = rr_pick(bus.req_valid, r_rr_ptr);
    assign w_found  = w_pick[ID_W];
    assign w_gnt    = w_pick[ID_W-1:0];
    assign w_xfer   = rst_n && w_credit && w_found;

    assign bus.req_ready = w_xfer ? (NREQ'(1) << w_gnt) : '0;
    assign bus.busy      = (w_outstanding != '0);
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
    assign bus.mul_asign = r_mul_asign;
    assign bus.mul_bsign = r_mul_bsign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_asign <= 1'b0;
            r_mul_bsign <= 1'b0;
            r_tag_vld   <= '0;
        end else begin
            if (w_xfer) begin
                r_rr_ptr    <= w_gnt + ID_W'(1);
                r_mul_a     <= bus.req_a[{w_gnt, 3'b000} +: DATA_W];
                r_mul_b     <= bus.req_b[{w_gnt, 3'b000} +: DATA_W];
                r_mul_asign <= bus.req_asign[w_gnt];
                r_mul_bsign <= bus.req_bsign[w_gnt];
            end
            r_tag_vld[0] <= w_xfer;
            for (int i = 1; i < MUL_LAT; i++) r_tag_vld[i] <= r_tag_vld[i-1];
        end
    end

    // Tag ids ride alongside the valids; their value is ignored when invalid.
    always_ff @(posedge clk) begin
        r_tag_id[0] <= w_gnt;
        for (int i = 1; i < MUL_LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
    end

`ifdef APPROX_TRUNC_EN
    assign w_push_m = bus.mul_m & ({PROD_W{1'b1}} << TRUNC_BITS);
`else
    assign w_push_m = bus.mul_m;
`endif

    assign w_push       = r_tag_vld[MUL_LAT-1];
    assign w_pop        = bus.rsp_ready && !w_empty;
    assign w_push_entry = '{id: r_tag_id[MUL_LAT-1], m: w_push_m, sign: bus.mul_sign};

    rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RSP_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    assign bus.rsp_valid = !w_empty;
    assign bus.rsp_id    = w_empty ? '0 : w_head.id;
    assign bus.rsp_m     = w_empty ? '0 : w_head.m;
    assign bus.rsp_sign  = w_empty ? 1'b0 : w_head.sign;

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(w_push && w_full && !w_pop));
    end
endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter MUL_LAT, default 1: clock cycles from a change on mul_* to a valid product on mul_m/mul_sign (range 1-4).
REQ-002 Parameter FIFO_DEPTH, default 4: response FIFO entries, power of two, 2-16.
REQ-003 Parameter TRUNC_BITS, default 4: product LSBs zeroed when APPROX_TRUNC_EN is defined.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  4  per-requester operand-pair valid.
REQ-007 req_ready  out  4  per-requester accept; at most one bit high per cycle.
REQ-008 req_a, req_b  in  32 each  four packed 8-bit magnitudes; requester i uses bits [8i+7:8i].
REQ-009 req_asign, req_bsign  in  4 each  per-requester operand sign bits.
REQ-010 mul_a, mul_b  out  8 each  registered magnitudes to the shared sign-magnitude multiplier.
REQ-011 mul_asign, mul_bsign  out  1 each  registered signs to the multiplier.
REQ-012 mul_m  in  16  multiplier product magnitude; mul_sign  in  1  product sign.
REQ-013 rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  2; rsp_m  out  16; rsp_sign  out  1  response channel.
REQ-014 busy  out  1  high while any operation is in flight or buffered.

Function
REQ-015 A transfer on port i SHALL occur on a rising edge with req_valid[i] and req_ready[i] both high.
REQ-016 Grant: round-robin starting at pointer rr_ptr (2 bits); the first valid requester at or after rr_ptr, modulo 4, gets req_ready high.
REQ-017 req_ready SHALL be all-zero when credit is exhausted: outstanding = in-flight tags + FIFO count; issue only when outstanding < FIFO_DEPTH, using registered counts (a same-cycle pop frees no credit).
REQ-018 On a transfer from port g, rr_ptr SHALL become (g+1) mod 4; with no transfer rr_ptr holds.
REQ-019 On a transfer, mul_a/mul_b/mul_asign/mul_bsign SHALL load port g operands at that edge; otherwise they hold.
REQ-020 Tag pipeline: MUL_LAT stages of {valid, id}; a tag enters at the transfer edge; when the last stage is valid, {id, mul_m, mul_sign} SHALL be pushed into the FIFO at that edge.
REQ-021 Latency: a transfer at edge k SHALL give rsp_valid high after edge k+MUL_LAT when the FIFO was empty; back-to-back issue, one per cycle.
REQ-022 rsp_valid = FIFO not empty; rsp_id/rsp_m/rsp_sign = FIFO head; pop on rsp_valid and rsp_ready.
REQ-023 Simultaneous push and pop SHALL be legal at any count, including full; overflow is impossible by REQ-017.
REQ-024 Response order SHALL equal grant order; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-025 busy = (outstanding != 0).

Reset
REQ-026 While rst_n is low: req_ready=0, mul_*=0, rsp_valid=0, rsp_id=0, rsp_m=0, rsp_sign=0, busy=0, rr_ptr=0, tags and FIFO cleared.
REQ-027 Reset mid-operation SHALL discard all in-flight and buffered results; the first grant after release follows rr_ptr=0.

Configuration
REQ-028 Macro APPROX_TRUNC_EN defined: rsp_m[TRUNC_BITS-1:0] SHALL be forced to 0 at FIFO push (approximate product); undefined: rsp_m is the exact mul_m and TRUNC_BITS is unused.

Structure
REQ-029 Package mult_arb_pkg SHALL hold NREQ=4, ID_W=2, the response-entry typedef {id, m, sign}, and the default parameter constants.
REQ-030 The response FIFO SHALL be a sub-module, rsp_fifo (synchronous, parameterised depth/width, full/empty/count outputs).

Verification
REQ-031 Port 0 a=3, b=1, asign=1, bsign=1, MUL_LAT=1 -> rsp_valid one cycle after accept, rsp_id=0, rsp_m=0x0003, rsp_sign=0.
REQ-032 Port 1 a=12, b=15, signs 1/1 -> rsp_id=1, rsp_m=0x00B4, rsp_sign=0; with APPROX_TRUNC_EN and TRUNC_BITS=4 -> rsp_m=0x00B0.
REQ-033 All four req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; responses arrive in the same id order.
REQ-034 rsp_ready=0, all ports valid -> exactly FIFO_DEPTH=4 accepts, then req_ready=0 and busy=1; rsp_ready=1 -> one pop per cycle, and issue resumes one cycle after the first pop.
REQ-035 rst_n pulsed low with 2 results buffered and 1 in flight -> rsp_valid=0, busy=0 immediately; no stale response after release.
REQ-036 Port 2 a=5, asign=0, bsign=1 (multiplier returns mul_sign=1) -> rsp_id=2, rsp_sign=1; the zero-operand product is passed through with the mul_sign value unchanged.
